// File: rtl/control_unit.sv
// Single-stage instruction decoder: classifies the opcode, extracts register
// fields and computes branch/jump targets, with every output registered.
module control_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instruction,
  input  logic [31:0] PC,
  output logic        alu,
  output logic        float,
  output logic        branch,
  output logic        jump,
  output logic        mem,
  output logic [4:0]  rs,
  output logic [4:0]  rt,
  output logic [4:0]  rd,
  output logic [4:0]  shamt,
  output logic [5:0]  funct,
  output logic [5:0]  alu_op,
  output logic [2:0]  cond,
  output logic [31:0] imm_ext,
  output logic [31:0] target,
  output logic [31:0] link,
  output logic [4:0]  dest,
  output logic        reg_write,
  output logic        fp_write,
  output logic        mem_read,
  output logic        mem_write,
  output logic        illegal
);

  typedef struct packed {
    logic        alu;
    logic        flt;
    logic        branch;
    logic        jump;
    logic        mem;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  shamt;
    logic [5:0]  funct;
    logic [5:0]  alu_op;
    logic [2:0]  cond;
    logic [31:0] imm_ext;
    logic [31:0] target;
    logic [31:0] link;
    logic [4:0]  dest;
    logic        reg_write;
    logic        fp_write;
    logic        mem_read;
    logic        mem_write;
    logic        illegal;
  } dec_t;

  typedef enum logic [2:0] {
    CLS_ALU    = 3'b000,
    CLS_BRANCH = 3'b001,
    CLS_JUMP   = 3'b010,
    CLS_MEM    = 3'b011,
    CLS_FLOAT  = 3'b100
  } cls_e;

  dec_t        dec_d, dec_q;
  logic [5:0]  op;
  logic [2:0]  sub;
  logic [31:0] imm_sx;

  assign op     = instruction[31:26];
  assign sub    = op[2:0];
  assign imm_sx = {{16{instruction[15]}}, instruction[15:0]};

  always_comb begin
    dec_d         = '0;
    dec_d.rs      = instruction[25:21];
    dec_d.rt      = instruction[20:16];
    dec_d.rd      = instruction[15:11];
    dec_d.shamt   = instruction[10:6];
    dec_d.funct   = instruction[5:0];
    dec_d.imm_ext = imm_sx;
    dec_d.cond    = sub;

    // The all-zero word is a NOP rather than an R-type add of r0 into r0.
    if (instruction != 32'h0) begin
      case (op[5:3])
        CLS_ALU: begin
          dec_d.alu       = 1'b1;
          dec_d.reg_write = 1'b1;
          if (op[2]) begin
            dec_d.dest   = instruction[20:16];
            dec_d.alu_op = op;
          end else begin
            dec_d.dest   = instruction[15:11];
            dec_d.alu_op = instruction[5:0];
          end
        end
        CLS_BRANCH: begin
          dec_d.branch = 1'b1;
          dec_d.target = PC + imm_sx;
        end
        CLS_JUMP: begin
          case (sub)
            3'd0: begin
              dec_d.jump   = 1'b1;
              dec_d.target = {PC[31:26], instruction[25:0]};
            end
            3'd1: begin
              dec_d.jump      = 1'b1;
              dec_d.target    = {PC[31:26], instruction[25:0]};
              dec_d.reg_write = 1'b1;
              dec_d.dest      = 5'd31;
              dec_d.link      = PC;
            end
            3'd2: dec_d.jump = 1'b1;
            default: dec_d.illegal = 1'b1;
          endcase
        end
        CLS_MEM: begin
          case (sub)
            3'd0: begin
              dec_d.mem       = 1'b1;
              dec_d.mem_read  = 1'b1;
              dec_d.reg_write = 1'b1;
              dec_d.dest      = instruction[20:16];
            end
            3'd1: begin
              dec_d.mem       = 1'b1;
              dec_d.mem_write = 1'b1;
            end
            default: dec_d.illegal = 1'b1;
          endcase
        end
        CLS_FLOAT: begin
          dec_d.flt      = 1'b1;
          dec_d.fp_write = 1'b1;
          dec_d.dest     = instruction[15:11];
          dec_d.alu_op   = instruction[5:0];
        end
        default: dec_d.illegal = 1'b1;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) dec_q <= '0;
    else        dec_q <= dec_d;
  end

  assign alu       = dec_q.alu;
  assign float     = dec_q.flt;
  assign branch    = dec_q.branch;
  assign jump      = dec_q.jump;
  assign mem       = dec_q.mem;
  assign rs        = dec_q.rs;
  assign rt        = dec_q.rt;
  assign rd        = dec_q.rd;
  assign shamt     = dec_q.shamt;
  assign funct     = dec_q.funct;
  assign alu_op    = dec_q.alu_op;
  assign cond      = dec_q.cond;
  assign imm_ext   = dec_q.imm_ext;
  assign target    = dec_q.target;
  assign link      = dec_q.link;
  assign dest      = dec_q.dest;
  assign reg_write = dec_q.reg_write;
  assign fp_write  = dec_q.fp_write;
  assign mem_read  = dec_q.mem_read;
  assign mem_write = dec_q.mem_write;
  assign illegal   = dec_q.illegal;

endmodule

// File: tb/tb_control_unit.sv
// Bench for control_unit: random instructions/PCs/resets compared every cycle
// against an opcode-table model, plus literal checks of known encodings.
module tb_control_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] instruction, PC;
  logic        alu, float, branch, jump, mem;
  logic [4:0]  rs, rt, rd, shamt, dest;
  logic [5:0]  funct, alu_op;
  logic [2:0]  cond;
  logic [31:0] imm_ext, target, link;
  logic        reg_write, fp_write, mem_read, mem_write, illegal;

  typedef struct packed {
    logic        alu, flt, br, jmp, mem;
    logic [4:0]  rs, rt, rd, shamt;
    logic [5:0]  funct, alu_op;
    logic [2:0]  cond;
    logic [31:0] imm_ext, target, link;
    logic [4:0]  dest;
    logic        reg_write, fp_write, mem_read, mem_write, illegal;
  } dec_t;

  dec_t dut_s, exp_s;
  logic armed = 1'b0;
  int   n_checks = 0;
  int   n_fails  = 0;

  always #5 clk = ~clk;

  control_unit dut (
    .clk(clk), .reset(reset), .instruction(instruction), .PC(PC),
    .alu(alu), .float(float), .branch(branch), .jump(jump), .mem(mem),
    .rs(rs), .rt(rt), .rd(rd), .shamt(shamt), .funct(funct),
    .alu_op(alu_op), .cond(cond), .imm_ext(imm_ext), .target(target),
    .link(link), .dest(dest), .reg_write(reg_write), .fp_write(fp_write),
    .mem_read(mem_read), .mem_write(mem_write), .illegal(illegal)
  );

  assign dut_s = {alu, float, branch, jump, mem, rs, rt, rd, shamt, funct,
                  alu_op, cond, imm_ext, target, link, dest, reg_write,
                  fp_write, mem_read, mem_write, illegal};

  // Opcode-table reference: class = op/8, variant = op%8.
  function automatic dec_t model(input logic [31:0] ins, input logic [31:0] pc);
    dec_t d;
    int op, cls, sub;
    logic [31:0] imm;
    op  = int'(ins[31:26]);
    cls = op / 8;
    sub = op % 8;
    imm = (ins[15] == 1'b1) ? (32'hFFFF0000 | 32'(ins[15:0])) : 32'(ins[15:0]);
    d = '0;
    d.rs = ins[25:21]; d.rt = ins[20:16]; d.rd = ins[15:11];
    d.shamt = ins[10:6]; d.funct = ins[5:0]; d.imm_ext = imm;
    d.cond = 3'(sub);
    if (ins == 32'd0) return d;
    if (cls == 0) begin
      d.alu = 1'b1; d.reg_write = 1'b1;
      if (sub < 4) begin d.dest = ins[15:11]; d.alu_op = ins[5:0]; end
      else         begin d.dest = ins[20:16]; d.alu_op = 6'(op); end
    end else if (cls == 1) begin
      d.br = 1'b1; d.target = pc + imm;
    end else if (cls == 2 && sub <= 2) begin
      d.jmp = 1'b1;
      if (sub != 2) d.target = (pc & 32'hFC000000) | (ins & 32'h03FFFFFF);
      if (sub == 1) begin d.reg_write = 1'b1; d.dest = 5'd31; d.link = pc; end
    end else if (cls == 3 && sub == 0) begin
      d.mem = 1'b1; d.mem_read = 1'b1; d.reg_write = 1'b1; d.dest = ins[20:16];
    end else if (cls == 3 && sub == 1) begin
      d.mem = 1'b1; d.mem_write = 1'b1;
    end else if (cls == 4) begin
      d.flt = 1'b1; d.fp_write = 1'b1; d.dest = ins[15:11]; d.alu_op = ins[5:0];
    end else begin
      d.illegal = 1'b1;
    end
    return d;
  endfunction

  always @(posedge clk) begin
    if (!reset) begin
      exp_s = '0;
      armed = 1'b1;
    end else begin
      exp_s = model(instruction, PC);
    end
  end

  always @(negedge clk) begin
    if (armed) begin
      n_checks++;
      if (dut_s !== exp_s) begin
        n_fails++;
        $display("FAIL model_cmp t=%0t instr=%h pc=%h got=%h expected=%h",
                 $time, instruction, PC, dut_s, exp_s);
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fails++;
      $display("FAIL %s got=%h expected=%h", nm, act, req);
    end
  endtask

  task automatic step(input logic r, input logic [31:0] ins, input logic [31:0] pc);
    @(negedge clk);
    reset = r; instruction = ins; PC = pc;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0; instruction = 32'h0; PC = 32'h0;

    // Reset held with a live instruction: outputs stay zero.
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 32'h00221820, 32'h1234);
      chk("reset_all_zero", 32'(dut_s == '0), 32'd1);
    end
    chk("reset_illegal", 32'(illegal), 32'd0);

    step(1'b1, 32'h00221820, 32'd0);
    chk("rtype_alu", 32'(alu), 32'd1);
    chk("rtype_rs", 32'(rs), 32'd1);
    chk("rtype_rt", 32'(rt), 32'd2);
    chk("rtype_rd", 32'(rd), 32'd3);
    chk("rtype_dest", 32'(dest), 32'd3);
    chk("rtype_alu_op", 32'(alu_op), 32'h20);
    chk("rtype_reg_write", 32'(reg_write), 32'd1);

    step(1'b1, 32'h1022FFFF, 32'd0);
    chk("itype_alu", 32'(alu), 32'd1);
    chk("itype_dest", 32'(dest), 32'd2);
    chk("itype_imm", imm_ext, 32'hFFFFFFFF);
    chk("itype_alu_op", 32'(alu_op), 32'h04);

    step(1'b1, 32'h20220004, 32'd10);
    chk("br_flag", 32'(branch), 32'd1);
    chk("br_cond", 32'(cond), 32'd0);
    chk("br_target", target, 32'd14);
    chk("br_reg_write", 32'(reg_write), 32'd0);

    step(1'b1, 32'h20000001, 32'hFFFFFFFF);
    chk("br_wrap_target", target, 32'd0);

    step(1'b1, 32'h44000100, 32'd5);
    chk("jal_jump", 32'(jump), 32'd1);
    chk("jal_target", target, 32'h100);
    chk("jal_reg_write", 32'(reg_write), 32'd1);
    chk("jal_dest", 32'(dest), 32'd31);
    chk("jal_link", link, 32'd5);

    step(1'b1, 32'h60220008, 32'd0);
    chk("lw_mem", 32'(mem), 32'd1);
    chk("lw_mem_read", 32'(mem_read), 32'd1);
    chk("lw_dest", 32'(dest), 32'd2);
    chk("lw_imm", imm_ext, 32'd8);

    step(1'b1, 32'hA0000000, 32'd7);
    chk("illegal_flag", 32'(illegal), 32'd1);
    chk("illegal_flags", 32'({alu, float, branch, jump, mem}), 32'd0);

    step(1'b1, 32'h0, 32'd9);
    chk("nop_zero", 32'(dut_s == '0), 32'd1);

    // A decode in flight is discarded when reset is sampled on the same edge.
    step(1'b0, 32'h44000100, 32'd5);
    chk("reset_discard", 32'(dut_s == '0), 32'd1);

    for (int i = 0; i < 3000; i++) begin
      logic [31:0] ins, pc;
      ins = $urandom;
      ins[31:26] = 6'($urandom_range(0, 63));
      if ($urandom_range(0, 15) == 0) ins = 32'h0;
      pc = ($urandom_range(0, 19) == 0) ? 32'hFFFFFFFF : $urandom;
      step(($urandom_range(0, 19) == 0) ? 1'b0 : 1'b1, ins, pc);
    end

    @(negedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
